display_scanner: RTL
====================

DISPLAY_SCANNER -- requirements
Module: display_scanner

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed 7-segment digits; valid range 2..8.
REQ-002 Clk  input  1  system clock; every register updates on rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset; sampled on rising Clk only.
REQ-004 Enable  input  1  scan enable; 0 blanks the display and parks the scanner.
REQ-005 Tick  input  1  scan-rate clock from the frequency divider ClkOut; treated as data, edge-detected in the Clk domain.
REQ-006 Value  input  4*NUM_DIGITS  hex digits to display, digit 0 in bits [3:0].
REQ-007 DigitEn  input  NUM_DIGITS  per-digit enable; 0 blanks that digit.
REQ-008 DpEn  input  NUM_DIGITS  per-digit decimal-point enable.
REQ-009 Anode  output  NUM_DIGITS  active-low digit select, registered.
REQ-010 Segments  output  7  active-low segments {g,f,e,d,c,b,a}, registered.
REQ-011 Dp  output  1  active-low decimal point, registered.
REQ-012 FrameDone  output  1  one-cycle pulse when the last digit's slot ends.

Function
REQ-013 States: IDLE, LOAD, SCAN; the FSM SHALL be encoded per the shared package enum.
REQ-014 IDLE: Anode all 1, Segments 7'h7F, Dp 1, index 0; go to LOAD when Enable=1.
REQ-015 LOAD (one cycle): shadow register <= Value, DigitEn and DpEn; index 0; go to SCAN.
REQ-016 SCAN: Anode SHALL drive exactly one bit low (bit = index) unless that digit is blanked, in which case Anode is all 1 and Segments 7'h7F.
REQ-017 Tick edge: TickQ <= Tick every cycle; TickRise = Tick & ~TickQ.
REQ-018 TickRise high after edge k SHALL advance index at edge k+1, with Anode/Segments/Dp for the new digit valid after that same edge k+1.
REQ-019 Index wraps NUM_DIGITS-1 -> 0; on that wrap FrameDone=1 for exactly one cycle and the shadow registers reload from Value/DigitEn/DpEn in the same cycle (no tearing mid-frame).
REQ-020 Value changes between wraps SHALL NOT affect the displayed digits.
REQ-021 Tick held high or held low SHALL hold the current digit indefinitely; no advance without a new rising edge.
REQ-022 Enable deasserted in any state: next edge -> IDLE, outputs blanked, FrameDone 0.
REQ-023 Enable and TickRise in the same cycle while in IDLE: TickRise ignored; LOAD still taken.
REQ-024 Decode: 0-F to standard hex glyphs (0=7'h40, 1=7'h79, 8=7'h00, F=7'h0E, active-low).
REQ-025 Dp = ~DpEn[index] when digit enabled, else 1.

Reset
REQ-026 Reset=1 at a rising Clk SHALL force: state IDLE, index 0, TickQ 0, shadow 0, Anode all 1, Segments 7'h7F, Dp 1, FrameDone 0.
REQ-027 Reset mid-scan SHALL take priority over Enable and TickRise; scanning restarts at digit 0 via LOAD.

Structure
REQ-028 Shared package SHALL hold the scan-state enum, BLANK_SEG constant (7'h7F) and the 16-entry hex glyph table.
REQ-029 One sub-module: hex_to_seg (4-bit in, 7-bit active-low out, combinational), instantiated once.
REQ-030 No clock derived from Tick; all logic in the Clk domain.

Verification
REQ-031 Reset, Enable=1, Value=16'h1234, DigitEn=4'hF, one Tick pulse -> Anode 1110 Segments 7'h19 (digit 4), next pulse Anode 1101 Segments 7'h30 (digit 3).
REQ-032 Four Tick pulses -> FrameDone one-cycle pulse on wrap 3->0; Value changed to 16'hABCD mid-frame appears only after the wrap.
REQ-033 DigitEn=4'b0101, DpEn=4'b0001 -> digits 1,3 fully blanked (Anode 1111, Segments 7'h7F); digit 0 Dp=0.
REQ-034 Tick held high 100 cycles -> exactly one advance; Tick held low -> no advance.
REQ-035 Enable dropped during digit 2 -> next cycle Anode 1111; re-enable -> LOAD then digit 0.
REQ-036 Reset asserted simultaneously with TickRise in SCAN -> all outputs at reset values next cycle, index 0.

Source files
------------

// File: rtl/display_scanner_pkg.sv
// Shared definitions for the multiplexed 7-segment display scanner:
// scan-state encoding, the blank segment pattern and the hex glyph table.
// Glyphs are active-low, bit order {g,f,e,d,c,b,a}.
package display_scanner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SCAN = 2'd2
    } scan_state_t;

    // All segments off (active-low).
    localparam logic [6:0] BLANK_SEG = 7'h7F;

    // Upper bound on NUM_DIGITS; sizes the digit index register.
    localparam int MAX_DIGITS = 8;
    localparam int IDX_W      = 3;

    // Standard hex glyphs 0-F, active-low {g,f,e,d,c,b,a}.
    localparam logic [6:0] HEX_GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
        7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
        7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
        7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
    };

endpackage

// File: rtl/display_scanner_hex_to_seg.sv
// Combinational hex-digit to 7-segment decoder (active-low outputs).
// Ports: digit - 4-bit hex value in
//        seg   - 7-bit segment pattern {g,f,e,d,c,b,a}, 0 = segment lit
module hex_to_seg
    import display_scanner_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = HEX_GLYPH[digit];
    end

endmodule

// File: rtl/display_scanner.sv
// Multiplexed 7-segment display scanner. Steps through NUM_DIGITS digits,
// one per rising edge of Tick (sampled as data in the Clk domain), and
// drives registered active-low Anode/Segments/Dp for the selected digit.
// Ports: Clk, Reset (sync, active-high), Enable (0 = blank and park),
//        Tick (scan rate), Value/DigitEn/DpEn (per-digit data, digit 0 in
//        the low bits), Anode/Segments/Dp (active-low, registered),
//        FrameDone (one-cycle pulse on wrap from last digit to digit 0).
module display_scanner
    import display_scanner_pkg::*;
#(
    parameter int NUM_DIGITS = 4
)
(
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    Enable,
    input  logic                    Tick,
    input  logic [4*NUM_DIGITS-1:0] Value,
    input  logic [NUM_DIGITS-1:0]   DigitEn,
    input  logic [NUM_DIGITS-1:0]   DpEn,
    output logic [NUM_DIGITS-1:0]   Anode,
    output logic [6:0]              Segments,
    output logic                    Dp,
    output logic                    FrameDone
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    scan_state_t             state;
    logic [IDX_W-1:0]        index;
    logic                    tick_q;
    logic                    tick_rise;

    // Per-frame snapshot of the inputs so a frame never mixes old and new data.
    logic [4*NUM_DIGITS-1:0] shadow_val;
    logic [NUM_DIGITS-1:0]   shadow_en;
    logic [NUM_DIGITS-1:0]   shadow_dp;

    logic                    advance;
    logic                    wrap;
    logic                    reload;
    logic [IDX_W-1:0]        next_idx;
    logic [4*NUM_DIGITS-1:0] src_val;
    logic [NUM_DIGITS-1:0]   src_en;
    logic [NUM_DIGITS-1:0]   src_dp;
    logic [3:0]              sel_nib;
    logic                    sel_en;
    logic                    sel_dp;
    logic [NUM_DIGITS-1:0]   anode_next;
    logic [6:0]              glyph;

    assign tick_rise = Tick & ~tick_q;

    // Outputs are registered from the digit that will be current after the
    // edge, so the index and its display update on the same clock edge.
    always_comb begin
        advance = (state == ST_SCAN) && tick_rise;
        wrap    = advance && (index == LAST_IDX);
        // When the shadow is being (re)loaded this edge, decode straight from
        // the inputs so digit 0 of the new frame shows the new data.
        reload  = (state == ST_LOAD) || wrap;

        next_idx = index;
        if (reload) begin
            next_idx = '0;
        end else if (advance) begin
            next_idx = index + IDX_W'(1);
        end

        src_val = reload ? Value   : shadow_val;
        src_en  = reload ? DigitEn : shadow_en;
        src_dp  = reload ? DpEn    : shadow_dp;

        sel_nib    = 4'h0;
        sel_en     = 1'b0;
        sel_dp     = 1'b0;
        anode_next = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (next_idx == IDX_W'(i)) begin
                sel_nib = src_val[i*4 +: 4];
                sel_en  = src_en[i];
                sel_dp  = src_dp[i];
                // A blanked digit leaves every anode off.
                anode_next[i] = ~src_en[i];
            end
        end
    end

    hex_to_seg u_hex_to_seg (
        .digit (sel_nib),
        .seg   (glyph)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= ST_IDLE;
            index      <= '0;
            tick_q     <= 1'b0;
            shadow_val <= '0;
            shadow_en  <= '0;
            shadow_dp  <= '0;
            Anode      <= '1;
            Segments   <= BLANK_SEG;
            Dp         <= 1'b1;
            FrameDone  <= 1'b0;
        end else begin
            tick_q    <= Tick;
            FrameDone <= 1'b0;

            if (!Enable) begin
                state    <= ST_IDLE;
                index    <= '0;
                Anode    <= '1;
                Segments <= BLANK_SEG;
                Dp       <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        // A tick rise seen here is deliberately ignored.
                        index    <= '0;
                        Anode    <= '1;
                        Segments <= BLANK_SEG;
                        Dp       <= 1'b1;
                        state    <= ST_LOAD;
                    end

                    ST_LOAD: begin
                        shadow_val <= Value;
                        shadow_en  <= DigitEn;
                        shadow_dp  <= DpEn;
                        index      <= '0;
                        Anode      <= anode_next;
                        Segments   <= sel_en ? glyph : BLANK_SEG;
                        Dp         <= sel_en ? ~sel_dp : 1'b1;
                        state      <= ST_SCAN;
                    end

                    ST_SCAN: begin
                        index    <= next_idx;
                        Anode    <= anode_next;
                        Segments <= sel_en ? glyph : BLANK_SEG;
                        Dp       <= sel_en ? ~sel_dp : 1'b1;
                        if (wrap) begin
                            shadow_val <= Value;
                            shadow_en  <= DigitEn;
                            shadow_dp  <= DpEn;
                            FrameDone  <= 1'b1;
                        end
                    end

                    default: begin
                        state    <= ST_IDLE;
                        index    <= '0;
                        Anode    <= '1;
                        Segments <= BLANK_SEG;
                        Dp       <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
